// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: two-entry skid buffer between pipeline stages with masked ctrl and stall counter
module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter logic [CTRL_W-1:0] CTRL_CLR_MASK = '1,
    parameter int CNT_W = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic              head_valid, skid_valid;
    logic [DATA_W-1:0] head_data, skid_data;
    logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
    logic              in_xfer, out_xfer, load_head_in, load_head_skid, load_skid;
    // in_ready comes straight from the skid flop so no out_ready path reaches upstream
    assign in_ready       = ~skid_valid;
    assign in_xfer        = in_valid & in_ready;
    assign out_xfer       = head_valid & out_ready;
    assign load_head_in   = ~flush & in_xfer & (~head_valid | out_xfer);
    assign load_head_skid = ~flush & out_xfer & skid_valid;
    assign load_skid      = ~flush & in_xfer & head_valid & ~out_xfer;
    assign out_valid      = head_valid;
    assign out_data       = head_data;
    assign out_ctrl       = head_valid ? head_ctrl : head_ctrl & ~CTRL_CLR_MASK;
    assign occupancy      = {1'b0, head_valid} + {1'b0, skid_valid};
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_data  <= '0;
            head_ctrl  <= '0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
            stall_cnt  <= '0;
        end else begin
            head_valid <= flush ? 1'b0 : out_xfer ? (skid_valid | in_xfer) : (head_valid | in_xfer);
            skid_valid <= flush ? 1'b0 : skid_valid ? ~out_xfer : load_skid;
            if (load_head_in) begin
                head_data <= in_data;
                head_ctrl <= in_ctrl;
            end else if (load_head_skid) begin
                head_data <= skid_data;
                head_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
            if (head_valid & ~out_ready & ~flush & (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of the skid buffer, plus a masked/narrow-counter instance
module tb_pipe_stage_buf;
    logic        CLK = 1'b0;
    logic        nRST, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic [15:0] in_ctrl;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [15:0] out_ctrl;
    logic [1:0]  occupancy;
    logic [7:0]  stall_cnt;
    logic        b_nrst, b_flush, b_in_valid, b_out_ready;
    logic [31:0] b_in_data;
    logic [15:0] b_in_ctrl;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [15:0] b_out_ctrl;
    logic [1:0]  b_occupancy;
    logic [1:0]  b_stall_cnt;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pipe_stage_buf dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_buf #(.CTRL_CLR_MASK(16'h00FF), .CNT_W(2)) dut_b (
        .CLK(CLK), .nRST(b_nrst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .occupancy(b_occupancy), .stall_cnt(b_stall_cnt)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_ctrl = '0;
        b_nrst = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0; b_in_ctrl = '0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        checks++; if (out_ctrl !== 16'h0) begin errors++; $display("FAIL reset_out_ctrl got %h want 0000", out_ctrl); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        nRST = 1'b1; b_nrst = 1'b1;
        tick();
    endtask

    task automatic test_stream;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h11; in_ctrl = 16'h0011;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin errors++; $display("FAIL stream_1 got v=%b d=%h want v=1 d=11", out_valid, out_data); end
        checks++; if (out_ctrl !== 16'h0011) begin errors++; $display("FAIL stream_ctrl got %h want 0011", out_ctrl); end
        in_data = 32'h22;
        tick();
        checks++; if (out_data !== 32'h22 || occupancy !== 2'd1) begin errors++; $display("FAIL stream_2 got d=%h occ=%0d want d=22 occ=1", out_data, occupancy); end
        in_data = 32'h33;
        tick();
        checks++; if (out_data !== 32'h33 || occupancy !== 2'd1) begin errors++; $display("FAIL stream_3 got d=%h occ=%0d want d=33 occ=1", out_data, occupancy); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL stream_stall got %0d want 0", stall_cnt); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA0; in_ctrl = 16'h00A0;
        tick();
        checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_first got occ=%0d rdy=%b want occ=1 rdy=1", occupancy, in_ready); end
        in_data = 32'hB0; in_ctrl = 16'h00B0;
        tick();
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got occ=%0d rdy=%b want occ=2 rdy=0", occupancy, in_ready); end
        checks++; if (out_data !== 32'hA0) begin errors++; $display("FAIL bp_head got %h want A0", out_data); end
        in_data = 32'hC0; in_ctrl = 16'h00C0;
        tick();
        checks++; if (occupancy !== 2'd2 || out_data !== 32'hA0 || stall_cnt !== 8'd2) begin errors++; $display("FAIL bp_hold got occ=%0d d=%h stall=%0d want occ=2 d=A0 stall=2", occupancy, out_data, stall_cnt); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 32'hB0 || occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_second got d=%h occ=%0d rdy=%b want d=B0 occ=1 rdy=1", out_data, occupancy, in_ready); end
        checks++; if (out_ctrl !== 16'h00B0) begin errors++; $display("FAIL bp_second_ctrl got %h want 00B0", out_ctrl); end
        tick();
        checks++; if (out_data !== 32'hC0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third got d=%h v=%b want d=C0 v=1", out_data, out_valid); end
        in_valid = 1'b0;
        tick();
        checks++; if (occupancy !== 2'd0 || stall_cnt !== 8'd2) begin errors++; $display("FAIL bp_drain got occ=%0d stall=%0d want occ=0 stall=2", occupancy, stall_cnt); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h01; in_ctrl = 16'hF001;
        tick();
        in_data = 32'h02; in_ctrl = 16'hF002;
        tick();
        checks++; if (occupancy !== 2'd2 || stall_cnt !== 8'd3) begin errors++; $display("FAIL flush_fill got occ=%0d stall=%0d want occ=2 stall=3", occupancy, stall_cnt); end
        flush = 1'b1; in_data = 32'hDD; in_ctrl = 16'h00DD;
        tick();
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got occ=%0d v=%b rdy=%b want occ=0 v=0 rdy=1", occupancy, out_valid, in_ready); end
        checks++; if (out_ctrl !== 16'h0) begin errors++; $display("FAIL flush_ctrl got %h want 0000", out_ctrl); end
        checks++; if (out_data !== 32'h01) begin errors++; $display("FAIL flush_data got %h want 01", out_data); end
        checks++; if (stall_cnt !== 8'd3) begin errors++; $display("FAIL flush_stall got %0d want 3", stall_cnt); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h01) begin errors++; $display("FAIL flush_after got v=%b d=%h want v=0 d=01", out_valid, out_data); end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 16'h0055;
        tick();
        in_data = 32'h66;
        tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL arst_fill got occ=%0d want 2", occupancy); end
        #2 nRST = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst_now got v=%b occ=%0d rdy=%b want v=0 occ=0 rdy=1", out_valid, occupancy, in_ready); end
        checks++; if (stall_cnt !== 8'd0 || out_data !== 32'h0) begin errors++; $display("FAIL arst_regs got stall=%0d d=%h want 0 0", stall_cnt, out_data); end
        in_data = 32'h77; in_ctrl = 16'h0077;
        #3 nRST = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h77) begin errors++; $display("FAIL arst_first got v=%b d=%h want v=1 d=77", out_valid, out_data); end
        in_valid = 1'b0;
    endtask

    task automatic test_mask;
        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 32'h9; b_in_ctrl = 16'hABCD;
        tick();
        checks++; if (b_out_ctrl !== 16'hABCD) begin errors++; $display("FAIL mask_valid got %h want ABCD", b_out_ctrl); end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        tick();
        checks++; if (b_out_valid !== 1'b0 || b_out_ctrl !== 16'hAB00) begin errors++; $display("FAIL mask_invalid got v=%b c=%h want v=0 c=AB00", b_out_valid, b_out_ctrl); end
    endtask

    task automatic test_saturation;
        logic [1:0] exp_cnt [6];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        b_nrst = 1'b0;
        #1 b_nrst = 1'b1;
        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 32'h5; b_in_ctrl = 16'h1234;
        tick();
        b_in_valid = 1'b0;
        checks++; if (b_stall_cnt !== 2'd0) begin errors++; $display("FAIL sat_start got %0d want 0", b_stall_cnt); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (b_stall_cnt !== exp_cnt[i]) begin errors++; $display("FAIL sat_cycle%0d got %0d want %0d", i, b_stall_cnt, exp_cnt[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_mask();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
